// File: rtl/sdf16_output_reorder_if.sv
// ----------------------------------------------------------------------------
// sdf16_output_reorder_if
// Stream bundle for the SDF-16 output reorder stage.
//   in_valid/in_data/in_ready       : bit-reversed sample stream from the NTT pipe
//   out_valid/out_ready             : natural-order output handshake
//   out_data/out_index/out_last     : reordered coefficient, its index, end of frame
//   frame_done                      : registered pulse after index 15 transfers
//   overflow                        : sticky dropped-sample flag
// Modports: master = producer/consumer side (testbench), slave = reorder block.
// ----------------------------------------------------------------------------
interface sdf16_output_reorder_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_index;
    logic              out_last;
    logic              frame_done;
    logic              overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, frame_done, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, frame_done, overflow
    );
endinterface

// File: rtl/sdf16_output_reorder.sv
// ----------------------------------------------------------------------------
// sdf16_output_reorder
// Captures the serial 16-point NTT result stream (bit-reversed order) into a
// ping-pong register buffer and replays each frame in natural order 0..15 with
// valid/ready flow control. One bank drains while the other fills.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high; discards any partial frame
//   bus  : sdf16_output_reorder_if.slave (input stream, output stream, status)
// Parameters:
//   DATA_W    : coefficient width
//   BITREV_EN : 1 = write address is bitrev4(wr_cnt), 0 = pass-through order
// ----------------------------------------------------------------------------
module sdf16_output_reorder #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BITREV_EN = 1
) (
    input logic                    clk,
    input logic                    rst,
    sdf16_output_reorder_if.slave  bus
);

    // Read side state is implied by whether the current read bank holds a frame.
    typedef enum logic {
        RdIdle,
        RdDrain
    } rd_state_e;

    logic [DATA_W-1:0] mem_q [2][16];
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [3:0]        wr_cnt_q, wr_cnt_d;
    logic [3:0]        rd_cnt_q, rd_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    rd_state_e         rd_state;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              wr_accept;
    logic              rd_xfer;
    logic [3:0]        wr_addr;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    always_comb begin
        rd_state  = full_q[rd_bank_q] ? RdDrain : RdIdle;
        in_ready  = !full_q[wr_bank_q];
        out_valid = 1'b0;
        out_data  = '0;
        unique case (rd_state)
            RdDrain: begin
                out_valid = 1'b1;
                out_data  = mem_q[rd_bank_q][rd_cnt_q];
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
        wr_accept = bus.in_valid && in_ready;
        rd_xfer   = out_valid && bus.out_ready;
        wr_addr   = (BITREV_EN != 0) ? bitrev4(wr_cnt_q) : wr_cnt_q;
    end

    // The write side only ever sets the flag of a non-full bank and the read side
    // only clears the flag of a full bank, so both updates can land in one cycle.
    always_comb begin
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q || (bus.in_valid && !in_ready);
        if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (rd_xfer) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                frame_done_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q        <= '{default: '0};
            full_q       <= 2'b00;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= 4'd0;
            rd_cnt_q     <= 4'd0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (wr_accept) begin
                mem_q[wr_bank_q][wr_addr] <= bus.in_data;
            end
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.out_index  = rd_cnt_q;
    assign bus.out_last   = out_valid && (rd_cnt_q == 4'd15);
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_sdf16_output_reorder.sv
// ----------------------------------------------------------------------------
// tb_sdf16_output_reorder
// Directed bench for sdf16_output_reorder. Two instances share clk/rst: one with
// bit reversal enabled (main tests) and one in pass-through mode.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later,
// which is the same cycle whose rising edge commits the handshake.
// ----------------------------------------------------------------------------
module tb_sdf16_output_reorder;
    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sdf16_output_reorder_if #(.DATA_W(DATA_W)) bus ();
    sdf16_output_reorder_if #(.DATA_W(DATA_W)) bus_p ();

    sdf16_output_reorder #(.DATA_W(DATA_W), .BITREV_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    sdf16_output_reorder #(.DATA_W(DATA_W), .BITREV_EN(0)) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (bus_p.slave)
    );

    function automatic logic [3:0] rev4(input logic [3:0] v);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = v[3-b];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus_p.in_valid = 1'b0; bus_p.in_data = '0; bus_p.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.out_data !== 16'd0 || bus.out_index !== 4'd0 || bus.out_last !== 1'b0)
            begin n_fail++; $display("FAIL rst_out_fields: got data %0d idx %0d last %b want 0 0 0", bus.out_data, bus.out_index, bus.out_last); end
        n_tests++; if (bus.frame_done !== 1'b0 || bus.overflow !== 1'b0)
            begin n_fail++; $display("FAIL rst_flags: got done %b ovf %b want 0 0", bus.frame_done, bus.overflow); end
        @(negedge clk);
        rst = 1'b0;
        // Seven samples of a frame that the reset below must discard.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(900 + k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (dut.wr_cnt_q !== 4'd7) begin n_fail++; $display("FAIL pre_rst_wr_cnt: got %0d want 7", dut.wr_cnt_q); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0)
            begin n_fail++; $display("FAIL midframe_rst_outputs: got rdy %b vld %b ovf %b want 1 0 0", bus.in_ready, bus.out_valid, bus.overflow); end
        n_tests++; if (dut.wr_cnt_q !== 4'd0 || dut.rd_cnt_q !== 4'd0 || bus.out_index !== 4'd0)
            begin n_fail++; $display("FAIL midframe_rst_counters: got wr %0d rd %0d want 0 0", dut.wr_cnt_q, dut.rd_cnt_q); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int k = 0, j = 0, last_acc = -100, first_vld = -1, dones = 0;
        logic exp_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (k < 16);
            bus.in_data   = 16'(100 + rev4(4'(k)));
            #1;
            n_tests++; if (bus.frame_done !== exp_done) begin n_fail++; $display("FAIL t2_frame_done cyc %0d: got %b want %b", c, bus.frame_done, exp_done); end
            if (bus.frame_done) dones++;
            exp_done = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                if (k == 15) last_acc = c;
                k++;
            end
            if (bus.out_valid) begin
                if (first_vld < 0) first_vld = c;
                n_tests++;
                if (bus.out_data !== 16'(100 + j) || bus.out_index !== 4'(j) || bus.out_last !== (j == 15)) begin
                    n_fail++;
                    $display("FAIL t2_out #%0d: got data %0d idx %0d last %b want %0d %0d %b", j, bus.out_data, bus.out_index, bus.out_last, 100 + j, j, (j == 15));
                end
                if (j == 15) exp_done = 1'b1;
                j++;
            end
        end
        bus.in_valid = 1'b0;
        n_tests++; if (j !== 16 || dones !== 1) begin n_fail++; $display("FAIL t2_counts: got outs %0d dones %0d want 16 1", j, dones); end
        n_tests++; if (first_vld !== last_acc + 1) begin n_fail++; $display("FAIL t2_latency: got first valid cyc %0d want %0d", first_vld, last_acc + 1); end
    endtask

    task automatic test_back_to_back();
        int k = 0, j = 0, drops = 0;
        int done_c[$];
        logic exp_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (k < 48);
            bus.in_data   = 16'(200 + 16 * (k / 16) + rev4(4'(k % 16)));
            #1;
            if (bus.in_valid && !bus.in_ready) drops++;
            n_tests++; if (bus.frame_done !== exp_done) begin n_fail++; $display("FAIL t3_frame_done cyc %0d: got %b want %b", c, bus.frame_done, exp_done); end
            if (bus.frame_done) done_c.push_back(c);
            exp_done = 1'b0;
            if (bus.in_valid && bus.in_ready) k++;
            if (bus.out_valid) begin
                n_tests++;
                if (bus.out_data !== 16'(200 + j) || bus.out_index !== 4'(j % 16)) begin
                    n_fail++;
                    $display("FAIL t3_out #%0d: got data %0d idx %0d want %0d %0d", j, bus.out_data, bus.out_index, 200 + j, j % 16);
                end
                if (j % 16 == 15) exp_done = 1'b1;
                j++;
            end
        end
        bus.in_valid = 1'b0;
        n_tests++; if (drops !== 0) begin n_fail++; $display("FAIL t3_in_ready_drop: got %0d stalled cycles want 0", drops); end
        n_tests++; if (j !== 48 || done_c.size() !== 3) begin n_fail++; $display("FAIL t3_counts: got outs %0d dones %0d want 48 3", j, done_c.size()); end
        if (done_c.size() == 3) begin
            n_tests++;
            if (done_c[1] - done_c[0] !== 16 || done_c[2] - done_c[1] !== 16) begin
                n_fail++;
                $display("FAIL t3_done_spacing: got gaps %0d %0d want 16 16", done_c[1] - done_c[0], done_c[2] - done_c[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int j = 0, bad_rdy = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(300 + 16 * (k / 16) + rev4(4'(k % 16)));
            #1;
            if (bus.in_ready !== 1'b1) bad_rdy++;
        end
        n_tests++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL t4_fill_ready: got %0d refused samples want 0", bad_rdy); end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            begin n_fail++; $display("FAIL t4_both_full: got rdy %b vld %b want 0 1", bus.in_ready, bus.out_valid); end
        n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL t4_ovf_before: got %b want 0", bus.overflow); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf_set: got %b want 1", bus.overflow); end
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd300 || bus.out_index !== 4'd0)
            begin n_fail++; $display("FAIL t4_stall_hold: got vld %b data %0d idx %0d want 1 300 0", bus.out_valid, bus.out_data, bus.out_index); end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            n_tests++; if (bus.in_ready !== (j >= 16)) begin n_fail++; $display("FAIL t4_drain_ready after %0d outs: got %b want %b", j, bus.in_ready, (j >= 16)); end
            if (bus.out_valid) begin
                n_tests++;
                if (bus.out_data !== 16'(300 + j)) begin n_fail++; $display("FAIL t4_out #%0d: got %0d want %0d", j, bus.out_data, 300 + j); end
                j++;
            end
        end
        n_tests++; if (j !== 32) begin n_fail++; $display("FAIL t4_count: got %0d outs want 32", j); end
        n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf_sticky: got %b want 1", bus.overflow); end
    endtask

    task automatic test_random_ready();
        int sent = 0, j = 0;
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 400 && j < 64; c++) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (sent < 64) && bus.in_ready;
            bus.in_data   = 16'(500 + 16 * (sent / 16) + rev4(4'(sent % 16)));
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (bus.out_data !== 16'(500 + j) || bus.out_index !== 4'(j % 16)) begin
                    n_fail++;
                    $display("FAIL t5_out #%0d: got data %0d idx %0d want %0d %0d", j, bus.out_data, bus.out_index, 500 + j, j % 16);
                end
                j++;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_tests++; if (sent !== 64 || j !== 64) begin n_fail++; $display("FAIL t5_counts: got sent %0d outs %0d want 64 64", sent, j); end
        n_tests++; if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b0)
            begin n_fail++; $display("FAIL t5_end_state: got ovf %b vld %b want 0 0", bus.overflow, bus.out_valid); end
    endtask

    task automatic test_passthrough();
        int k = 0, j = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bus_p.out_ready = 1'b1;
            bus_p.in_valid  = (k < 16);
            bus_p.in_data   = 16'(k);
            #1;
            if (bus_p.in_valid && bus_p.in_ready) k++;
            if (bus_p.out_valid) begin
                n_tests++;
                if (bus_p.out_data !== 16'(j) || bus_p.out_index !== 4'(j)) begin
                    n_fail++;
                    $display("FAIL t6_out #%0d: got data %0d idx %0d want %0d %0d", j, bus_p.out_data, bus_p.out_index, j, j);
                end
                j++;
            end
        end
        bus_p.in_valid = 1'b0;
        n_tests++; if (j !== 16) begin n_fail++; $display("FAIL t6_count: got %0d outs want 16", j); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random_ready();
        test_passthrough();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
